mux4_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4:1 single-bit mux datapath. Four requesters compete for the shared mux; the block grants one at a time, drives the 2-bit select ({c,d}), bounds each tenure with a hold counter, and registers the selected data bit. It sits directly in front of the gate-level 4:1 mux and replaces any static select wiring.

---
 rtl/mux4_pkg.sv | 38 +++
 rtl/mux4_rr_arbiter_if.sv | 30 +++
 rtl/rr_pick4.sv | 18 +
 rtl/mux4_rr_arbiter.sv | 97 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_pkg.sv
// Shared types, widths and the rotating-search helper for the 4:1 mux arbiter.
package mux4_pkg;

  localparam int IDX_W = 2;
  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit at or after start, wrapping mod N_REQ.
  function automatic pick_t next_idx(input logic [N_REQ-1:0] req,
                                     input logic [IDX_W-1:0] start);
    pick_t            pick;
    logic [IDX_W-1:0] k;
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = start + IDX_W'(i);
      if (req[k]) begin
        pick.found = 1'b1;
        pick.idx   = k;
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] idx2oh(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between requesters (master) and the arbiter (slave).
interface mux4_rr_arbiter_if;
  import mux4_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] sel;
  logic             busy;
  logic             y;

  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  busy,
    input  y
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output busy,
    output y
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or after i_start.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_start,
  input  logic [N_REQ-1:0] i_mask,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  pick_t w_pick;

  assign w_pick  = next_idx(i_req & ~i_mask, i_start);
  assign o_idx   = w_pick.idx;
  assign o_found = w_pick.found;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 mux: one-hot grant, 2-bit select, bounded
// tenure and a registered copy of the selected data bit.
module mux4_rr_arbiter
  import mux4_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.slave   arb
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           r_state;
  logic [IDX_W-1:0] r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_sel;
  logic             r_y;

  logic [IDX_W-1:0] w_start;
  logic [N_REQ-1:0] w_mask;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // r_last equals the owner while granted, so one picker serves both paths:
  // masking the owner makes the search cover only the other requesters.
  assign w_start = r_last + IDX_W'(1);
  assign w_mask  = (r_state == GRANT) ? idx2oh(r_last) : '0;

  rr_pick4 u_pick (
    .i_req   (arb.req),
    .i_start (w_start),
    .i_mask  (w_mask),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(3);
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_y     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_y <= 1'b0;
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= idx2oh(w_idx);
            r_sel   <= w_idx;
            r_last  <= w_idx;
            r_cnt   <= CntOne;
          end
        end
        GRANT: begin
          r_y <= arb.din[r_sel];
          if (!arb.req[r_sel]) begin
            if (w_found) begin
              r_gnt  <= idx2oh(w_idx);
              r_sel  <= w_idx;
              r_last <= w_idx;
              r_cnt  <= CntOne;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_cnt   <= '0;
            end
          end else if (w_found && (r_cnt >= HoldMax)) begin
            r_gnt  <= idx2oh(w_idx);
            r_sel  <= w_idx;
            r_last <= w_idx;
            r_cnt  <= CntOne;
          end else if (r_cnt < HoldMax) begin
            r_cnt <= r_cnt + CntOne;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign arb.gnt  = r_gnt;
  assign arb.sel  = r_sel;
  assign arb.busy = |r_gnt;
  assign arb.y    = r_y;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized bench for mux4_rr_arbiter against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if arb ();

  mux4_rr_arbiter #(
    .HOLD_MAX (HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: owner < 0 means nobody holds the mux.
  int m_owner;
  int m_last;
  int m_cnt;
  int m_sel;
  bit m_y;

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
    m_sel   = 0;
    m_y     = 1'b0;
  endtask

  function automatic int find(input logic [3:0] r, input int from, input bit excl);
    for (int off = 1; off <= 4; off++) begin
      int k;
      k = (from + off) % 4;
      if (!(excl && k == from) && r[k]) return k;
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_last  = w;
    m_sel   = w;
    m_cnt   = 1;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d);
    int w;
    m_y = (m_owner >= 0) ? d[m_sel] : 1'b0;
    if (m_owner < 0) begin
      w = find(r, m_last, 1'b0);
      if (w >= 0) take(w);
    end else begin
      w = find(r, m_owner, 1'b1);
      if (!r[m_owner]) begin
        if (w >= 0) take(w);
        else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end else if (w >= 0 && m_cnt >= HOLD) begin
        take(w);
      end else if (m_cnt < HOLD) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e_gnt;
    e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check({tag, ".gnt"}, arb.gnt, e_gnt);
    check({tag, ".sel"}, {2'b00, arb.sel}, 4'(m_sel));
    check({tag, ".busy"}, {3'b000, arb.busy}, {3'b000, m_owner >= 0});
    check({tag, ".y"}, {3'b000, arb.y}, {3'b000, m_y});
    check({tag, ".onehot0"}, {3'b000, $onehot0(arb.gnt)}, 4'b0001);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(arb.req, arb.din);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] din_at_edge;
    rst_n   = 1'b0;
    arb.req = '0;
    arb.din = '0;
    model_reset();
    #12;
    check("reset.gnt", arb.gnt, 4'b0000);
    check("reset.sel", {2'b00, arb.sel}, 4'b0000);
    check("reset.busy", {3'b000, arb.busy}, 4'b0000);
    check("reset.y", {3'b000, arb.y}, 4'b0000);
    rst_n = 1'b1;

    // Single requester 0: grant on the sampling edge, data one edge later.
    arb.req = 4'b0001;
    arb.din = 4'b0001;
    tick("first");
    check("first.gnt", arb.gnt, 4'b0001);
    check("first.busy", {3'b000, arb.busy}, 4'b0001);
    tick("first_y");
    check("first.y", {3'b000, arb.y}, 4'b0001);

    // Full contention: each requester owns exactly HOLD cycles in turn.
    do_reset();
    arb.req = 4'b1111;
    for (int j = 1; j <= 20; j++) begin
      tick("rr");
      check("rr.order", arb.gnt, 4'b0001 << (((j - 1) / HOLD) % 4));
    end

    // Sole requester keeps the grant indefinitely.
    do_reset();
    arb.req = 4'b0100;
    for (int j = 0; j < 20; j++) begin
      tick("sole");
      check("sole.gnt", arb.gnt, 4'b0100);
    end

    // Owner 1 releases while 3 waits: direct hand-over, then full release.
    do_reset();
    arb.din = 4'b1000;
    arb.req = 4'b0010;
    tick("rel_a");
    arb.req = 4'b1010;
    tick("rel_b");
    arb.req = 4'b1000;
    tick("rel_c");
    check("rel.handover", arb.gnt, 4'b1000);
    check("rel.sel", {2'b00, arb.sel}, 4'b0011);
    arb.req = 4'b0000;
    tick("rel_d");
    check("rel.idle_gnt", arb.gnt, 4'b0000);
    check("rel.idle_busy", {3'b000, arb.busy}, 4'b0000);
    tick("rel_e");
    check("rel.idle_y", {3'b000, arb.y}, 4'b0000);

    // Asynchronous reset in the middle of requester 3's tenure.
    do_reset();
    arb.din = 4'b1111;
    arb.req = 4'b1000;
    tick("mid_a");
    tick("mid_b");
    tick("mid_c");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid.gnt", arb.gnt, 4'b0000);
    check("mid.busy", {3'b000, arb.busy}, 4'b0000);
    check("mid.y", {3'b000, arb.y}, 4'b0000);
    check("mid.sel", {2'b00, arb.sel}, 4'b0000);
    #1;
    rst_n   = 1'b1;
    arb.req = 4'b1001;
    tick("mid_after");
    check("mid.first_after", arb.gnt, 4'b0001);

    // Toggling data during requester 1's grant appears on y one edge later.
    do_reset();
    arb.req = 4'b0010;
    tick("tog_grant");
    for (int j = 0; j < 10; j++) begin
      arb.din     = {$urandom_range(0, 1) == 1, ~arb.din[2], ~arb.din[1], arb.din[0]};
      din_at_edge = arb.din;
      tick("tog");
      check("tog.y", {3'b000, arb.y}, {3'b000, din_at_edge[1]});
    end

    // Randomized traffic with sticky requests and occasional resets.
    do_reset();
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(0, 3) == 0) arb.req = 4'($urandom);
      arb.din = 4'($urandom);
      if ($urandom_range(0, 249) == 0) do_reset();
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
